mlp_seq_ctrl: RTL
=================

Name: mlp_seq_ctrl

Overview:
Sequencer for the MLP inference datapath behind the AXI-Stream slave.
- Consumes one run's stream: image pixels, then per-neuron weights and bias for the hidden layer, then for the output layer.
- Routes each accepted beat to the image buffer or the external MAC/activation datapath, and writes hidden activations back.
- Takes the argmax over output neurons and publishes ready/cl_num to the AXI-Lite register bank.

Parameters:
- DATA_W, 32, stream tdata width
- WIDTH, 18, pixel/weight/bias width; uses tdata[WIDTH-1:0]
- RES_W, 18, signed neuron result width
- IMG_LEN, 784, pixels per image = weights per hidden neuron
- HID_N, 30, hidden neurons = weights per output neuron
- OUT_N, 10, output neurons (must be ≤16)
- ADDR_W, 10, buffer address width (≥ clog2(IMG_LEN))

Ports:
- clk, in, 1, clock
- reset, in, 1, reset
- start, in, 1, start register bit; rising edge starts a run
- ready, out, 1, 1 = idle/result valid
- cl_num, out, 4, index of winning output neuron
- s_axis_tdata, in, DATA_W, stream data
- s_axis_tvalid, in, 1, stream valid
- s_axis_tready, out, 1, stream ready
- dp_data, out, WIDTH, registered copy of accepted tdata[WIDTH-1:0]
- img_we, out, 1, image buffer write strobe
- img_addr, out, ADDR_W, image buffer write address
- mac_en, out, 1, MAC step strobe (weight on dp_data)
- mac_clr, out, 1, with mac_en: load product instead of accumulate
- x_sel, out, 1, operand source: 0 image buffer, 1 hidden buffer
- x_rd_addr, out, ADDR_W, operand read address for this MAC step
- bias_en, out, 1, bias strobe (bias on dp_data); datapath finalises neuron
- res_valid, in, 1, one-cycle pulse: neuron result available
- res_data, in, RES_W, signed neuron result (post-activation)
- hid_we, out, 1, hidden buffer write strobe (datapath supplies data)
- hid_addr, out, ADDR_W, hidden buffer write address

Behaviour:
- Interface: single clock clk; reset asynchronous, active-high; all state and outputs clear immediately on reset assertion.
- Reset values:
  - ready=1, cl_num=0, s_axis_tready=0.
  - All strobes 0; dp_data, img_addr, x_rd_addr, hid_addr = 0; x_sel=0.
  - State IDLE; counters pix, nrn = 0; max register cleared.
- States: IDLE, IMG, W1, B1, WAIT1, W2, B2, WAIT2, FIN.
- s_axis_tready is a combinational decode: 1 in IMG, W1, B1, W2, B2; 0 otherwise.
- Beat accepted when tvalid & tready at a rising edge.
- All datapath outputs are registered. Strobes pulse for exactly the cycle after acceptance, with dp_data/addresses valid in that same cycle.
- start: registered for edge detection.
  - Rising edge in IDLE → IMG, pix=0, ready=0 next cycle.
  - Edges in any other state are ignored.
  - Level high does not retrigger.
- IMG:
  - Each beat: img_we, img_addr=pix, pix++.
  - After beat IMG_LEN-1 → W1, pix=0, nrn=0.
- W1:
  - Each beat: mac_en, x_sel=0, x_rd_addr=pix, mac_clr=(pix==0), pix++.
  - After beat IMG_LEN-1 → B1.
- B1: one beat → bias_en, then WAIT1.
- WAIT1: on res_valid → hid_we pulse next cycle with hid_addr=nrn.
  - If nrn==HID_N-1 → W2, nrn=0.
  - Else nrn++ → W1.
  - pix=0 on either transition.
- W2 / B2 / WAIT2: as W1/B1/WAIT1, with x_sel=1 and per-neuron length HID_N.
- WAIT2 on res_valid:
  - nrn==0: max=res_data, best=0.
  - Otherwise, signed res_data > max: max=res_data, best=nrn. Ties keep the lower index.
  - If nrn==OUT_N-1 → FIN, else nrn++, pix=0 → W2.
- FIN: one cycle; cl_num=best; ready=1 from next cycle; → IDLE.
- cl_num holds until the next completed run. It is not cleared by start.
- res_valid outside WAIT1/WAIT2 is ignored.
- tdata bits above WIDTH-1 are ignored; tlast is not used.
- A mid-run reset aborts the run with no partial outputs. IDLE with ready=1 follows release.

Test Plan:
- Reset then idle: ready=1, cl_num=0, tready=0; no strobes over 20 cycles even with tvalid=1.
- Full run (IMG_LEN=4, HID_N=2, OUT_N=3), tvalid held high:
  - Stream is 4 pixels, then 2×(4 w + bias), then 3×(2 w + bias).
  - Datapath model returns res_valid 3 cycles after each bias_en, results {5,-2,9}.
  - Required: img_addr 0..3, mac_clr on 1st weight of each neuron, hid_addr 0,1, cl_num=2, ready=1.
- Ties and negatives: output results {-7,-3,-3} → cl_num=1; rerun with {4,4,4} → cl_num=0.
- Throttling: random tvalid gaps plus extra beats offered during WAIT states. Required: tready=0 in WAIT, no beats lost or duplicated, x_rd_addr sequence unchanged.
- Start handling:
  - start held high across the whole run: exactly one run.
  - A second rising edge mid-run: ignored.
  - start 1→0 after FIN: no new run until the next rising edge.
- Reset asserted during W1 at pix=2: outputs drop within the same cycle. After release: IDLE, ready=1, cl_num=0; a new run completes correctly.

Source files
------------

// File: rtl/mlp_seq_ctrl.sv
// Stream sequencer for the MLP inference datapath: routes pixels/weights/biases,
// writes back hidden activations and keeps a running argmax over the output layer.
module mlp_seq_ctrl #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned WIDTH   = 18,
  parameter int unsigned RES_W   = 18,
  parameter int unsigned IMG_LEN = 784,
  parameter int unsigned HID_N   = 30,
  parameter int unsigned OUT_N   = 10,
  parameter int unsigned ADDR_W  = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    ready,
  output logic [3:0]              cl_num,
  input  logic [DATA_W-1:0]       s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [WIDTH-1:0]        dp_data,
  output logic                    img_we,
  output logic [ADDR_W-1:0]       img_addr,
  output logic                    mac_en,
  output logic                    mac_clr,
  output logic                    x_sel,
  output logic [ADDR_W-1:0]       x_rd_addr,
  output logic                    bias_en,
  input  logic                    res_valid,
  input  logic signed [RES_W-1:0] res_data,
  output logic                    hid_we,
  output logic [ADDR_W-1:0]       hid_addr
);

  typedef enum logic [3:0] {
    StIdle, StImg, StW1, StB1, StWait1, StW2, StB2, StWait2, StFin
  } state_e;

  localparam logic [ADDR_W-1:0] ImgLast = ADDR_W'(IMG_LEN - 1);
  localparam logic [ADDR_W-1:0] HidLast = ADDR_W'(HID_N - 1);
  localparam logic [ADDR_W-1:0] OutLast = ADDR_W'(OUT_N - 1);
  localparam logic [ADDR_W-1:0] One     = ADDR_W'(1);

  state_e                    state_q, state_d;
  logic                      start_q;
  logic [ADDR_W-1:0]         pix_q, pix_d, nrn_q, nrn_d;
  logic signed [RES_W-1:0]   max_q, max_d;
  logic [3:0]                best_q, best_d;
  logic                      ready_q, ready_d;
  logic [3:0]                cl_num_q, cl_num_d;
  logic [WIDTH-1:0]          dp_data_q, dp_data_d;
  logic                      img_we_q, img_we_d, mac_en_q, mac_en_d, mac_clr_q, mac_clr_d;
  logic                      x_sel_q, x_sel_d, bias_en_q, bias_en_d, hid_we_q, hid_we_d;
  logic [ADDR_W-1:0]         img_addr_q, img_addr_d, x_rd_addr_q, x_rd_addr_d;
  logic [ADDR_W-1:0]         hid_addr_q, hid_addr_d;
  logic                      accept, start_rise;
  logic                      unused_tdata;

  assign s_axis_tready = (state_q == StImg) || (state_q == StW1) || (state_q == StB1) ||
                         (state_q == StW2)  || (state_q == StB2);
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign start_rise    = start & ~start_q;
  assign unused_tdata  = ^s_axis_tdata[DATA_W-1:WIDTH];

  always_comb begin
    state_d     = state_q;
    pix_d       = pix_q;
    nrn_d       = nrn_q;
    max_d       = max_q;
    best_d      = best_q;
    ready_d     = ready_q;
    cl_num_d    = cl_num_q;
    dp_data_d   = dp_data_q;
    img_addr_d  = img_addr_q;
    x_sel_d     = x_sel_q;
    x_rd_addr_d = x_rd_addr_q;
    hid_addr_d  = hid_addr_q;
    img_we_d    = 1'b0;
    mac_en_d    = 1'b0;
    mac_clr_d   = 1'b0;
    bias_en_d   = 1'b0;
    hid_we_d    = 1'b0;
    if (accept) dp_data_d = s_axis_tdata[WIDTH-1:0];

    unique case (state_q)
      StIdle: begin
        if (start_rise) begin
          state_d = StImg;
          pix_d   = '0;
          nrn_d   = '0;
          ready_d = 1'b0;
        end
      end
      StImg: begin
        if (accept) begin
          img_we_d   = 1'b1;
          img_addr_d = pix_q;
          pix_d      = pix_q + One;
          if (pix_q == ImgLast) begin
            state_d = StW1;
            pix_d   = '0;
            nrn_d   = '0;
          end
        end
      end
      StW1, StW2: begin
        if (accept) begin
          mac_en_d    = 1'b1;
          mac_clr_d   = (pix_q == '0);
          x_sel_d     = (state_q == StW2);
          x_rd_addr_d = pix_q;
          pix_d       = pix_q + One;
          if (state_q == StW1 && pix_q == ImgLast) state_d = StB1;
          if (state_q == StW2 && pix_q == HidLast) state_d = StB2;
        end
      end
      StB1: begin
        if (accept) begin
          bias_en_d = 1'b1;
          state_d   = StWait1;
        end
      end
      StB2: begin
        if (accept) begin
          bias_en_d = 1'b1;
          state_d   = StWait2;
        end
      end
      StWait1: begin
        if (res_valid) begin
          hid_we_d   = 1'b1;
          hid_addr_d = nrn_q;
          pix_d      = '0;
          if (nrn_q == HidLast) begin
            state_d = StW2;
            nrn_d   = '0;
          end else begin
            state_d = StW1;
            nrn_d   = nrn_q + One;
          end
        end
      end
      StWait2: begin
        if (res_valid) begin
          // Strict compare so ties keep the lower neuron index.
          if (nrn_q == '0 || res_data > max_q) begin
            max_d  = res_data;
            best_d = 4'(nrn_q);
          end
          if (nrn_q == OutLast) begin
            state_d = StFin;
          end else begin
            state_d = StW2;
            nrn_d   = nrn_q + One;
            pix_d   = '0;
          end
        end
      end
      StFin: begin
        cl_num_d = best_q;
        ready_d  = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      start_q     <= 1'b0;
      pix_q       <= '0;
      nrn_q       <= '0;
      max_q       <= '0;
      best_q      <= '0;
      ready_q     <= 1'b1;
      cl_num_q    <= '0;
      dp_data_q   <= '0;
      img_we_q    <= 1'b0;
      img_addr_q  <= '0;
      mac_en_q    <= 1'b0;
      mac_clr_q   <= 1'b0;
      x_sel_q     <= 1'b0;
      x_rd_addr_q <= '0;
      bias_en_q   <= 1'b0;
      hid_we_q    <= 1'b0;
      hid_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      start_q     <= start;
      pix_q       <= pix_d;
      nrn_q       <= nrn_d;
      max_q       <= max_d;
      best_q      <= best_d;
      ready_q     <= ready_d;
      cl_num_q    <= cl_num_d;
      dp_data_q   <= dp_data_d;
      img_we_q    <= img_we_d;
      img_addr_q  <= img_addr_d;
      mac_en_q    <= mac_en_d;
      mac_clr_q   <= mac_clr_d;
      x_sel_q     <= x_sel_d;
      x_rd_addr_q <= x_rd_addr_d;
      bias_en_q   <= bias_en_d;
      hid_we_q    <= hid_we_d;
      hid_addr_q  <= hid_addr_d;
    end
  end

  assign ready     = ready_q;
  assign cl_num    = cl_num_q;
  assign dp_data   = dp_data_q;
  assign img_we    = img_we_q;
  assign img_addr  = img_addr_q;
  assign mac_en    = mac_en_q;
  assign mac_clr   = mac_clr_q;
  assign x_sel     = x_sel_q;
  assign x_rd_addr = x_rd_addr_q;
  assign bias_en   = bias_en_q;
  assign hid_we    = hid_we_q;
  assign hid_addr  = hid_addr_q;

endmodule
